// File: rtl/uart_sim_pkg.sv
// Shared types and constants for the simulation-side UART receive feeder.
package uart_sim_pkg;

  typedef logic [7:0] uart_ch_t;

  localparam uart_ch_t DEFAULT_EMPTY_CH = 8'hff;
  localparam int       GAP_W            = 16;

  typedef logic [GAP_W-1:0] gap_cnt_t;

  typedef enum logic {
    GAP_READY = 1'b0,
    GAP_WAIT  = 1'b1
  } gap_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sim_fifo.sv
// Circular-buffer FIFO with occupancy counter and combinational head read.
module sim_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full/empty come from registered occupancy only, so a same-cycle pop never frees a slot early.
  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_in_feeder.sv
// Feeds buffered host characters to the SoC's polled UART input, one per read strobe,
// with an optional dead time after each pop and an idle code when nothing is ready.
module uart_in_feeder
  import uart_sim_pkg::*;
#(
  parameter int       DEPTH    = 16,
  parameter int       GAP      = 0,
  parameter uart_ch_t EMPTY_CH = DEFAULT_EMPTY_CH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   host_valid,
  input  uart_ch_t               host_ch,
  output logic                   host_ready,
  input  logic                   io_uart_in_valid,
  output uart_ch_t               io_uart_in_ch,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            empty_polls
);

  gap_state_t r_state;
  gap_state_t w_state_next;
  gap_cnt_t   r_gap_cnt;
  gap_cnt_t   w_gap_cnt_next;
  logic [15:0] r_empty_polls;

  uart_ch_t   w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_avail;
  logic       w_pop;
  logic       w_empty_poll;

  sim_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(uart_ch_t))
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (host_valid),
    .push_data (host_ch),
    .pop       (w_pop),
    .head      (w_head),
    .count     (count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign host_ready    = ~w_full;
  assign w_avail       = ~w_empty && (r_state == GAP_READY);
  assign io_uart_in_ch = w_avail ? w_head : EMPTY_CH;
  assign empty_polls   = r_empty_polls;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= GAP_READY;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_gap_cnt <= w_gap_cnt_next;
    end
  end

  // READY holds exactly when gap_cnt is zero; any strobe not served from READY is an empty poll.
  always_comb begin
    w_state_next   = r_state;
    w_gap_cnt_next = r_gap_cnt;
    w_pop          = 1'b0;
    w_empty_poll   = 1'b0;
    case (r_state)
      GAP_READY: begin
        if (io_uart_in_valid) begin
          if (!w_empty) begin
            w_pop          = 1'b1;
            w_gap_cnt_next = GAP_W'(GAP);
            w_state_next   = (GAP == 0) ? GAP_READY : GAP_WAIT;
          end else begin
            w_empty_poll = 1'b1;
          end
        end
      end
      GAP_WAIT: begin
        w_gap_cnt_next = r_gap_cnt - 1'b1;
        w_empty_poll   = io_uart_in_valid;
        if (r_gap_cnt == GAP_W'(1)) begin
          w_state_next = GAP_READY;
        end
      end
      default: begin
        w_state_next   = GAP_READY;
        w_gap_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_empty_polls <= '0;
    end else if (w_empty_poll) begin
      r_empty_polls <= sat_inc16(r_empty_polls);
    end
  end

endmodule

// File: tb/tb_uart_in_feeder.sv
// Bench for uart_in_feeder: a GAP=0 and a GAP=3 instance share stimulus; table, directed and random checks.
module tb_uart_in_feeder;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       host_valid = 1'b0;
  logic [7:0] host_ch = 8'h00;
  logic       strobe = 1'b0;

  logic       ready0, ready3;
  logic [7:0] ch0, ch3;
  logic [4:0] cnt0, cnt3;
  logic [15:0] polls0, polls3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  uart_in_feeder #(.DEPTH(16), .GAP(0), .EMPTY_CH(8'hff)) u_dut0 (
    .clock            (clock),
    .reset_n          (reset_n),
    .host_valid       (host_valid),
    .host_ch          (host_ch),
    .host_ready       (ready0),
    .io_uart_in_valid (strobe),
    .io_uart_in_ch    (ch0),
    .count            (cnt0),
    .empty_polls      (polls0)
  );

  uart_in_feeder #(.DEPTH(16), .GAP(3), .EMPTY_CH(8'hff)) u_dut3 (
    .clock            (clock),
    .reset_n          (reset_n),
    .host_valid       (host_valid),
    .host_ch          (host_ch),
    .host_ready       (ready3),
    .io_uart_in_valid (strobe),
    .io_uart_in_ch    (ch3),
    .count            (cnt3),
    .empty_polls      (polls3)
  );

  // Reference model: a queue per instance plus the earliest cycle a character may be exposed again.
  logic [7:0] mq0[$];
  logic [7:0] mq3[$];
  int nok[2];
  int mpolls[2];
  int mcyc;
  int gaps[2] = '{0, 3};

  typedef struct {
    logic       hv;
    logic [7:0] ch;
    logic       st;
    logic [7:0] e_ch0;
    int         e_cnt0;
    int         e_pl0;
    logic [7:0] e_ch3;
    int         e_cnt3;
    int         e_pl3;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic hv, input logic [7:0] c, input logic st);
    @(negedge clock);
    host_valid = hv;
    host_ch    = c;
    strobe     = st;
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    host_valid = 1'b0;
    host_ch    = 8'h00;
    strobe     = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    mq0.delete();
    mq3.delete();
    nok    = '{0, 0};
    mpolls = '{0, 0};
    mcyc   = 0;
  endtask

  task automatic model_step();
    int         sz;
    logic       avail;
    logic       exp_ready;
    logic [7:0] exp_ch;
    for (int k = 0; k < 2; k++) begin
      sz        = (k == 0) ? mq0.size() : mq3.size();
      avail     = (sz > 0) && (mcyc >= nok[k]);
      exp_ready = (sz < 16);
      exp_ch    = 8'hff;
      if (avail) exp_ch = (k == 0) ? mq0[0] : mq3[0];
      chk($sformatf("rand%0d.ready", k), {31'd0, (k == 0) ? ready0 : ready3}, {31'd0, exp_ready});
      chk($sformatf("rand%0d.count", k), {27'd0, (k == 0) ? cnt0 : cnt3}, sz);
      chk($sformatf("rand%0d.polls", k), {16'd0, (k == 0) ? polls0 : polls3}, mpolls[k]);
      if (strobe) chk($sformatf("rand%0d.ch", k), {24'd0, (k == 0) ? ch0 : ch3}, {24'd0, exp_ch});
      if (strobe) begin
        if (avail) begin
          if (k == 0) void'(mq0.pop_front()); else void'(mq3.pop_front());
          nok[k] = mcyc + gaps[k] + 1;
        end else if (mpolls[k] < 65535) begin
          mpolls[k]++;
        end
      end
      if (host_valid && exp_ready) begin
        if (k == 0) mq0.push_back(host_ch); else mq3.push_back(host_ch);
      end
    end
    mcyc++;
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, ".ready0"}, {31'd0, ready0}, 32'd1);
    chk({tag, ".ready3"}, {31'd0, ready3}, 32'd1);
    chk({tag, ".ch0"}, {24'd0, ch0}, 32'hff);
    chk({tag, ".ch3"}, {24'd0, ch3}, 32'hff);
    chk({tag, ".cnt0"}, {27'd0, cnt0}, 32'd0);
    chk({tag, ".cnt3"}, {27'd0, cnt3}, 32'd0);
    chk({tag, ".polls0"}, {16'd0, polls0}, 32'd0);
    chk({tag, ".polls3"}, {16'd0, polls3}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           hv   ch     st    ch0    c0 p0  ch3    c3 p3
    tbl[0]  = '{1'b0, 8'h00, 1'b1, 8'hff, 0, 0, 8'hff, 0, 0};
    tbl[1]  = '{1'b1, 8'h41, 1'b0, 8'hff, 0, 1, 8'hff, 0, 1};
    tbl[2]  = '{1'b1, 8'h42, 1'b0, 8'h41, 1, 1, 8'h41, 1, 1};
    tbl[3]  = '{1'b1, 8'h43, 1'b0, 8'h41, 2, 1, 8'h41, 2, 1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'h41, 3, 1, 8'h41, 3, 1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'h42, 2, 1, 8'hff, 2, 1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h43, 1, 1, 8'hff, 2, 2};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'hff, 0, 1, 8'hff, 2, 3};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'hff, 0, 2, 8'h42, 2, 4};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'hff, 0, 3, 8'hff, 1, 4};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'hff, 0, 3, 8'hff, 1, 4};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'hff, 0, 3, 8'hff, 1, 4};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 8'hff, 0, 3, 8'h43, 1, 4};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'hff, 0, 4, 8'hff, 0, 4};

    // Reset state, both during and just after reset.
    reset_n = 1'b0;
    #12;
    chk_idle_state("in_reset");
    do_reset();
    #1;
    chk_idle_state("after_reset");

    // Table: empty poll, three pushes, strobes under GAP=0 and GAP=3.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].hv, tbl[i].ch, tbl[i].st);
      $display("vec %0d: hv=%0b ch=%h st=%0b | dut0 ch=%h cnt=%0d polls=%0d | dut3 ch=%h cnt=%0d polls=%0d",
               i, tbl[i].hv, tbl[i].ch, tbl[i].st, ch0, cnt0, polls0, ch3, cnt3, polls3);
      chk($sformatf("vec%0d.ch0", i), {24'd0, ch0}, {24'd0, tbl[i].e_ch0});
      chk($sformatf("vec%0d.cnt0", i), {27'd0, cnt0}, tbl[i].e_cnt0);
      chk($sformatf("vec%0d.polls0", i), {16'd0, polls0}, tbl[i].e_pl0);
      chk($sformatf("vec%0d.ch3", i), {24'd0, ch3}, {24'd0, tbl[i].e_ch3});
      chk($sformatf("vec%0d.cnt3", i), {27'd0, cnt3}, tbl[i].e_cnt3);
      chk($sformatf("vec%0d.polls3", i), {16'd0, polls3}, tbl[i].e_pl3);
      chk($sformatf("vec%0d.ready0", i), {31'd0, ready0}, 32'd1);
    end

    // Fill to DEPTH, refused 17th push, push+pop while full.
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'h80 + 8'(i), 1'b0);
    chk("fill.pre_last_cnt0", {27'd0, cnt0}, 32'd15);
    chk("fill.pre_last_ready0", {31'd0, ready0}, 32'd1);
    drive(1'b1, 8'h99, 1'b0);
    $display("fill: cnt0=%0d ready0=%0b cnt3=%0d ready3=%0b", cnt0, ready0, cnt3, ready3);
    chk("fill.full_ready0", {31'd0, ready0}, 32'd0);
    chk("fill.full_ready3", {31'd0, ready3}, 32'd0);
    chk("fill.full_cnt0", {27'd0, cnt0}, 32'd16);
    drive(1'b1, 8'h9a, 1'b1);
    chk("fill.refused_cnt0", {27'd0, cnt0}, 32'd16);
    chk("fill.pushpop_ready0", {31'd0, ready0}, 32'd0);
    chk("fill.pushpop_ch0", {24'd0, ch0}, 32'h80);
    chk("fill.pushpop_ch3", {24'd0, ch3}, 32'h80);
    drive(1'b0, 8'h00, 1'b0);
    chk("fill.after_cnt0", {27'd0, cnt0}, 32'd15);
    chk("fill.after_cnt3", {27'd0, cnt3}, 32'd15);
    chk("fill.after_ready0", {31'd0, ready0}, 32'd1);
    chk("fill.after_ready3", {31'd0, ready3}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d.ch0", i), {24'd0, ch0}, 32'h81 + i);
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("drain.cnt0", {27'd0, cnt0}, 32'd0);

    // Steady push+pop at count=5 across pointer wrap.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(i + 5), 1'b1);
      chk($sformatf("wrap%0d.ch0", i), {24'd0, ch0}, i);
      chk($sformatf("wrap%0d.cnt0", i), {27'd0, cnt0}, 32'd5);
    end
    drive(1'b0, 8'h00, 1'b0);
    $display("wrap: cnt0=%0d head=%h", cnt0, ch0);
    chk("wrap.end_cnt0", {27'd0, cnt0}, 32'd5);
    chk("wrap.end_head0", {24'd0, ch0}, 32'd40);

    // Asynchronous reset mid-stream with count=7 and gap_cnt=2 in the GAP=3 instance.
    do_reset();
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'ha0 + 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("midrst.pre_cnt3", {27'd0, cnt3}, 32'd7);
    chk("midrst.pre_polls3", {16'd0, polls3}, 32'd1);
    chk("midrst.pre_ch3", {24'd0, ch3}, 32'hff);
    reset_n = 1'b0;
    #1;
    $display("midrst: cnt3=%0d ch3=%h polls3=%0d", cnt3, ch3, polls3);
    chk_idle_state("midrst.async");
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b1, 8'h55, 1'b0);
    chk_idle_state("midrst.next");
    drive(1'b0, 8'h00, 1'b1);
    chk("midrst.resume_ch3", {24'd0, ch3}, 32'h55);
    chk("midrst.resume_ch0", {24'd0, ch0}, 32'h55);

    // Randomized traffic against the queue model, with alternating fill pressure.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int pv;
      pv = ((i / 150) % 2 == 0) ? 35 : 85;
      drive(($urandom_range(99) < pv) ? 1'b1 : 1'b0, 8'($urandom), ($urandom_range(99) < 50) ? 1'b1 : 1'b0);
      model_step();
    end
    $display("random: %0d cycles, model depths %0d/%0d, polls %0d/%0d", mcyc, mq0.size(), mq3.size(), mpolls[0], mpolls[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
